uart_rx_decoder: RTL

//  Synthesizable UART receiver for the servant SoC's serial output q (8N1, LSB first, idle high).

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_rx_decoder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, data width and timer-width helper for the UART receiver
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    // Width needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - metastability chain for the serial line, preset to the idle (high) level
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], rx};
        end
    end

    assign rx_s = chain[STAGES-1];

endmodule

// File: rtl/uart_rx_decoder.sv
// rtl/uart_rx_decoder.sv - UART receiver 8N1 (8E1 when UART_RX_PARITY_EN is defined) with valid/ready byte output
module uart_rx_decoder
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD_RATE   = 57600,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_frame_err,
    output logic              o_overrun,
    output logic              o_busy
);

    localparam int DIV = CLK_FREQ / BAUD_RATE;
    localparam int TW  = clog2(DIV);
    localparam logic [TW-1:0] TIMER_LAST  = TW'(DIV - 1);
    // Entering START at this value makes the first tick land half a bit later.
    localparam logic [TW-1:0] TIMER_START = TW'(DIV - DIV / 2);

    logic              rx_s;
    state_t            state, state_n;
    logic [TW-1:0]     timer, timer_n;
    logic [2:0]        bit_idx, bit_idx_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic [DATA_W-1:0] data_n;
    logic              valid_n, frame_err_n, overrun_n;
    logic              tick;
    logic              parity_ok;

    uart_rx_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (i_clk),
        .rst  (i_rst),
        .rx   (i_rx),
        .rx_s (rx_s)
    );

    assign tick   = (timer == TIMER_LAST);
    assign o_busy = (state != IDLE);

`ifdef UART_RX_PARITY_EN
    logic par_bit, par_bit_n;
    assign parity_ok = ((^shift) == par_bit);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            par_bit <= 1'b0;
        end else begin
            par_bit <= par_bit_n;
        end
    end
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            timer       <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            timer       <= timer_n;
            bit_idx     <= bit_idx_n;
            shift       <= shift_n;
            o_data      <= data_n;
            o_valid     <= valid_n;
            o_frame_err <= frame_err_n;
            o_overrun   <= overrun_n;
        end
    end

    always_comb begin
        state_n     = state;
        timer_n     = tick ? '0 : timer + TW'(1);
        bit_idx_n   = bit_idx;
        shift_n     = shift;
        data_n      = o_data;
        valid_n     = o_valid && !i_ready;
        frame_err_n = 1'b0;
        overrun_n   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_n   = par_bit;
`endif

        case (state)
            IDLE: begin
                timer_n = '0;
                // BREAK only exits on a high line, so a low level here is always a fresh falling edge.
                if (!rx_s) begin
                    state_n = START;
                    timer_n = TIMER_START;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_s) begin
                        state_n = IDLE;
                    end else begin
                        state_n   = DATA;
                        bit_idx_n = '0;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_n[bit_idx] = rx_s;
                    bit_idx_n        = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    par_bit_n = rx_s;
                    state_n   = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (rx_s && parity_ok) begin
                        state_n = IDLE;
                        if (!o_valid || i_ready) begin
                            data_n  = shift;
                            valid_n = 1'b1;
                        end else begin
                            overrun_n = 1'b1;
                        end
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = BREAK;
                    end
                end
            end
            BREAK: begin
                timer_n = '0;
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
